// File: rtl/axis_count_src_pkg.sv
// Shared state encoding and default parameter values for the AXI-Stream counting source.
package axis_count_src_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int unsigned     DEF_DATA_W     = 16;
  localparam logic [15:0]     DEF_START_VAL  = 16'd5555;
  localparam int unsigned     DEF_STEP       = 1;
  localparam int unsigned     DEF_PKT_LEN    = 8;
  localparam int unsigned     DEF_GAP_CYCLES = 2;

endpackage

// File: rtl/axis_count_src.sv
// AXI-Stream source emitting packets of an incrementing counter with idle gaps between packets.
// Optional tlast output is enabled by defining AXIS_COUNT_SRC_TLAST_EN.
module axis_count_src
  import axis_count_src_pkg::*;
#(
  parameter int unsigned       DATA_W     = DEF_DATA_W,
  parameter logic [DATA_W-1:0] START_VAL  = DATA_W'(DEF_START_VAL),
  parameter int unsigned       STEP       = DEF_STEP,
  parameter int unsigned       PKT_LEN    = DEF_PKT_LEN,
  parameter int unsigned       GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic [DATA_W-1:0] tdata,
  output logic              tvalid,
  input  logic              tready,
  output logic [15:0]       pkt_count,
  output logic              busy
`ifdef AXIS_COUNT_SRC_TLAST_EN
  ,
  output logic              tlast
`endif
);

  localparam logic [15:0]       LAST_BEAT = 16'(PKT_LEN - 1);
  localparam logic [7:0]        LAST_GAP  = 8'(GAP_CYCLES - 1);
  localparam logic [DATA_W-1:0] STEP_W    = DATA_W'(STEP);
  localparam bit                HAS_GAP   = (GAP_CYCLES != 0);

  state_t      state;
  logic [15:0] beat_cnt;
  logic [7:0]  gap_cnt;

  // Counter advance wraps silently modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] next_data(input logic [DATA_W-1:0] d);
    return d + STEP_W;
  endfunction

  assign tvalid = (state == ST_SEND);
  assign busy   = (state != ST_IDLE);
`ifdef AXIS_COUNT_SRC_TLAST_EN
  assign tlast  = tvalid && (beat_cnt == LAST_BEAT);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tdata     <= START_VAL;
      pkt_count <= '0;
      beat_cnt  <= '0;
      gap_cnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (enable) state <= ST_SEND;
        end
        ST_SEND: begin
          if (tready) begin
            tdata <= next_data(tdata);
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt  <= '0;
              pkt_count <= pkt_count + 16'd1;
              // enable is only consulted here, at the packet boundary
              if (HAS_GAP)     state <= ST_GAP;
              else if (!enable) state <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 16'd1;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == LAST_GAP) begin
            gap_cnt <= '0;
            state   <= enable ? ST_SEND : ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_count_src.sv
// Scoreboard bench for axis_count_src: default, wrap-around and gapless single-beat instances.
module tb_axis_count_src;

  localparam int unsigned START  = 5555;
  localparam int unsigned STEPV  = 1;
  localparam int unsigned PLEN   = 8;
  localparam int unsigned GAPC   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        enable = 1'b0, en_w = 1'b0, en_g = 1'b0;
  logic        tready = 1'b0, rdy_w = 1'b1, rdy_g = 1'b1;
  logic [15:0] tdata, tdata_w, tdata_g;
  logic        tvalid, tvalid_w, tvalid_g;
  logic [15:0] pkt_count, pkt_count_w, pkt_count_g;
  logic        busy, busy_w, busy_g;
`ifdef AXIS_COUNT_SRC_TLAST_EN
  logic        tlast, tlast_w, tlast_g;
`endif

  axis_count_src u_main (
    .clk(clk), .rst(rst), .enable(enable), .tdata(tdata), .tvalid(tvalid),
    .tready(tready), .pkt_count(pkt_count), .busy(busy)
`ifdef AXIS_COUNT_SRC_TLAST_EN
    , .tlast(tlast)
`endif
  );

  axis_count_src #(.START_VAL(16'hFFFE)) u_wrap (
    .clk(clk), .rst(rst), .enable(en_w), .tdata(tdata_w), .tvalid(tvalid_w),
    .tready(rdy_w), .pkt_count(pkt_count_w), .busy(busy_w)
`ifdef AXIS_COUNT_SRC_TLAST_EN
    , .tlast(tlast_w)
`endif
  );

  axis_count_src #(.PKT_LEN(1), .GAP_CYCLES(0)) u_gap0 (
    .clk(clk), .rst(rst), .enable(en_g), .tdata(tdata_g), .tvalid(tvalid_g),
    .tready(rdy_g), .pkt_count(pkt_count_g), .busy(busy_g)
`ifdef AXIS_COUNT_SRC_TLAST_EN
    , .tlast(tlast_g)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];
  int beats_seen = 0;
  logic prev_hold = 1'b0;
  logic [15:0] prev_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset is the stimulus that restarts the counter sequence, so the expected beats are queued here.
  task automatic do_reset(input logic en);
    step();
    rst = 1'b1;
    enable = en;
    en_w = 1'b0;
    en_g = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 100; i++) exp_q.push_back(16'(START + i * STEPV));
    step();
    rst = 1'b0;
  endtask

  // Monitor: every accepted beat of the main instance is popped and compared.
  always @(negedge clk) begin
    if (rst) begin
      beats_seen = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_tvalid", tvalid, 1);
        check("hold_tdata", tdata, prev_data);
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_underflow: got beat %0d, expected none", tdata);
        end else begin
          check("beat_tdata", tdata, exp_q.pop_front());
        end
        check("beat_pkt_count", pkt_count, (beats_seen / PLEN) % 65536);
`ifdef AXIS_COUNT_SRC_TLAST_EN
        check("beat_tlast", tlast, (beats_seen % PLEN) == PLEN - 1);
`endif
        beats_seen++;
      end
      prev_hold = tvalid && !tready;
      prev_data = tdata;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [15:0] got[4];
    int n;

    // Continuous acceptance: 8 beats, 2 idle cycles, then the next packet.
    do_reset(1'b0);
    @(negedge clk);
    check("rst_tvalid", tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_tdata", tdata, START);
    check("rst_pkt_count", pkt_count, 0);
    step();
    enable = 1'b1;
    tready = 1'b1;
    @(negedge clk);
    check("latency_tvalid", tvalid, 0);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      check("t1_tvalid", tvalid, (c % (PLEN + GAPC)) < PLEN);
      if (c == PLEN) check("t1_pkt_count", pkt_count, 1);
      if (c == PLEN + GAPC) check("t1_next_pkt", tdata, START + PLEN);
    end

    // Random backpressure: 40 beats in order, 5 packets.
    do_reset(1'b0);
    enable = 1'b1;
    cyc = 0;
    while (beats_seen < 40 && cyc < 2000) begin
      step();
      tready = (beats_seen < 40) ? 1'($urandom % 2) : 1'b0;
      cyc++;
    end
    tready = 1'b0;
    repeat (4) step();
    check("t2_beats", beats_seen, 40);
    check("t2_pkt_count", pkt_count, 5);

    // enable dropped mid-packet: packet still completes, then IDLE.
    do_reset(1'b0);
    enable = 1'b1;
    tready = 1'b1;
    cyc = 0;
    while (beats_seen < 3 && cyc < 100) begin step(); cyc++; end
    enable = 1'b0;
    repeat (10) step();
    @(negedge clk);
    check("t3_beats", beats_seen, PLEN);
    check("t3_pkt_count", pkt_count, 1);
    check("t3_busy", busy, 0);
    check("t3_tvalid", tvalid, 0);

    // Reset during a stalled beat: beat dropped, sequence restarts.
    do_reset(1'b0);
    enable = 1'b1;
    tready = 1'b1;
    cyc = 0;
    while (beats_seen < 3 && cyc < 100) begin step(); cyc++; end
    tready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("t4_pre_tvalid", tvalid, 1);
    do_reset(1'b1);
    @(negedge clk);
    check("t4_tvalid", tvalid, 0);
    check("t4_tdata", tdata, START);
    check("t4_pkt_count", pkt_count, 0);
    check("t4_busy", busy, 0);
    @(negedge clk);
    check("t4_restart_tvalid", tvalid, 1);
    check("t4_restart_tdata", tdata, START);
    enable = 1'b0;

    // Wrap-around from FFFE.
    do_reset(1'b0);
    en_w = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      if (tvalid_w && rdy_w) begin got[n] = tdata_w; n++; end
      cyc++;
    end
    check("t5_count", n, 4);
    for (int i = 0; i < 4; i++) check("t5_wrap_tdata", got[i], 16'(32'hFFFE + i));

    // Gapless single-beat packets.
    do_reset(1'b0);
    en_g = 1'b1;
    @(negedge clk);
    check("t6_latency", tvalid_g, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t6_tvalid", tvalid_g, 1);
      check("t6_tdata", tdata_g, 16'(START + i));
      check("t6_pkt_count", pkt_count_g, i);
`ifdef AXIS_COUNT_SRC_TLAST_EN
      check("t6_tlast", tlast_g, 1);
`endif
    end
    en_g = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("t6_idle_busy", busy_g, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
